// File: rtl/fp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_pkg : shared state encoding and format helpers for fp_addsub  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fp_pkg;

   typedef enum logic [3:0] {
      ST_GET_A  = 4'd0,
      ST_GET_B  = 4'd1,
      ST_UNPACK = 4'd2,
      ST_ALIGN  = 4'd3,
      ST_ADD    = 4'd4,
      ST_NORM   = 4'd5,
      ST_ROUND  = 4'd6,
      ST_PACK   = 4'd7,
      ST_PUT_Z  = 4'd8
   } state_t;

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_exp_max(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

   // Canonical quiet NaN, right-aligned in a 64-bit container.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_addsub_if : operand/result stb-ack handshake bundle           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fp_addsub_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic [W-1:0] input_a;
   logic         input_a_stb;
   logic         input_a_ack;
   logic [W-1:0] input_b;
   logic         input_op;
   logic         input_b_stb;
   logic         input_b_ack;
   logic [W-1:0] output_z;
   logic [2:0]   output_flags;
   logic         output_z_stb;
   logic         output_z_ack;

   modport master (
      output input_a, input_a_stb, input_b, input_op, input_b_stb, output_z_ack,
      input  input_a_ack, input_b_ack, output_z, output_flags, output_z_stb
   );

   modport slave (
      input  input_a, input_a_stb, input_b, input_op, input_b_stb, output_z_ack,
      output input_a_ack, input_b_ack, output_z, output_flags, output_z_stb
   );
endinterface
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_lzc : combinational leading-zero counter (WIDTH when all zero)|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CW-1:0]    o_count
);
   logic [CW-1:0] w_count;

   // Ascending scan: the highest set bit is the last one to write.
   always_comb begin
      w_count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (i_data[i]) w_count = CW'(WIDTH - 1 - i);
      end
   end

   assign o_count = w_count;
endmodule
`default_nettype wire

// File: rtl/fp_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_addsub : multi-cycle IEEE-754 adder/subtractor, RNE, denormals|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fp_addsub
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic       clk,
   input  logic       rst,
   fp_addsub_if.slave bus
);
   localparam int W   = fp_width(EXP_W, MAN_W);
   localparam int SW  = MAN_W + 5;
   localparam int XW  = EXP_W + 2;
   localparam int LZW = MAN_W + 4;
   localparam int CW  = $clog2(LZW + 1);
   localparam logic [63:0]        QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]       QNAN      = QNAN_WIDE[W-1:0];
   localparam logic [EXP_W-1:0]   E_ONES    = '1;
   localparam logic [XW-1:0]      EXP_MAX_X = XW'(fp_exp_max(EXP_W));

   state_t                 state_q, state_d;
   logic [W-1:0]           a_q, a_d, b_q, b_d, z_q, z_d, special_z_q, special_z_d;
   logic                   op_q, op_d, a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
   logic [2:0]             flags_q, flags_d, special_flags_q, special_flags_d;
   logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_q, sign_d;
   logic                   special_q, special_d, inexact_q, inexact_d;
   logic signed [XW-1:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_q, exp_d;
   logic [SW-1:0]          sig_a_q, sig_a_d, sig_b_q, sig_b_d, sig_q, sig_d;

   // Operand decode
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_sa, w_sb;
   logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic             w_special;
   logic [W-1:0]     w_special_z;
   logic [2:0]       w_special_flags;

   assign w_ea     = a_q[W-2:MAN_W];
   assign w_eb     = b_q[W-2:MAN_W];
   assign w_fa     = a_q[MAN_W-1:0];
   assign w_fb     = b_q[MAN_W-1:0];
   assign w_sa     = a_q[W-1];
   assign w_sb     = b_q[W-1] ^ op_q;
   assign w_a_nan  = (w_ea == E_ONES) && (w_fa != '0);
   assign w_b_nan  = (w_eb == E_ONES) && (w_fb != '0);
   assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
   assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
   assign w_a_inf  = (w_ea == E_ONES) && (w_fa == '0);
   assign w_b_inf  = (w_eb == E_ONES) && (w_fb == '0);
   assign w_a_zero = (w_ea == '0) && (w_fa == '0);
   assign w_b_zero = (w_eb == '0) && (w_fb == '0);

   always_comb begin
      w_special       = 1'b1;
      w_special_z     = '0;
      w_special_flags = 3'b000;
      if (w_a_nan || w_b_nan) begin
         w_special_z     = QNAN;
         w_special_flags = {w_a_snan | w_b_snan, 2'b00};
      end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
         w_special_z     = QNAN;
         w_special_flags = 3'b100;
      end else if (w_a_inf) begin
         w_special_z = {w_sa, E_ONES, {MAN_W{1'b0}}};
      end else if (w_b_inf) begin
         w_special_z = {w_sb, E_ONES, {MAN_W{1'b0}}};
      end else if (w_a_zero && w_b_zero) begin
         w_special_z = {w_sa & w_sb, {(W-1){1'b0}}};
      end else if (w_a_zero) begin
         w_special_z = {w_sb, b_q[W-2:0]};
      end else if (w_b_zero) begin
         w_special_z = a_q;
      end else begin
         w_special = 1'b0;
      end
   end

   // Alignment: the smaller-exponent significand is shifted, lost bits fold into sticky
   logic          w_a_big;
   logic [XW-1:0] w_diff;
   logic [SW-1:0] w_sh_in, w_sh_mask, w_sh_out;

   assign w_a_big   = (exp_a_q >= exp_b_q);
   assign w_diff    = w_a_big ? XW'(exp_a_q - exp_b_q) : XW'(exp_b_q - exp_a_q);
   assign w_sh_in   = w_a_big ? sig_b_q : sig_a_q;
   assign w_sh_mask = ~({SW{1'b1}} << w_diff);
   assign w_sh_out  = (w_sh_in >> w_diff) | {{(SW-1){1'b0}}, |(w_sh_in & w_sh_mask)};

   // Normalisation shift, clamped so the exponent never drops below 1
   logic [CW-1:0] w_lz;
   logic [XW-1:0] w_lz_x, w_lim, w_norm_sh;

   fp_lzc #(.WIDTH(LZW), .CW(CW)) u_lzc (
      .i_data  (sig_q[SW-2:0]),
      .o_count (w_lz)
   );

   assign w_lz_x    = XW'(w_lz);
   assign w_lim     = XW'(exp_q) - XW'(1);
   assign w_norm_sh = (w_lz_x > w_lim) ? w_lim : w_lz_x;

   // Round to nearest even on guard/round/sticky
   logic             w_round_up;
   logic [MAN_W+1:0] w_rnd;

   assign w_round_up = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
   assign w_rnd      = {1'b0, sig_q[SW-2:3]} + (MAN_W+2)'(w_round_up);

   always_comb begin
      state_d         = state_q;
      a_d             = a_q;
      b_d             = b_q;
      op_d            = op_q;
      a_ack_d         = a_ack_q;
      b_ack_d         = b_ack_q;
      z_d             = z_q;
      flags_d         = flags_q;
      z_stb_d         = z_stb_q;
      sign_a_d        = sign_a_q;
      sign_b_d        = sign_b_q;
      exp_a_d         = exp_a_q;
      exp_b_d         = exp_b_q;
      sig_a_d         = sig_a_q;
      sig_b_d         = sig_b_q;
      special_d       = special_q;
      special_z_d     = special_z_q;
      special_flags_d = special_flags_q;
      sign_d          = sign_q;
      exp_d           = exp_q;
      sig_d           = sig_q;
      inexact_d       = inexact_q;
      case (state_q)
         ST_GET_A: begin
            a_ack_d = 1'b1;
            if (a_ack_q && bus.input_a_stb) begin
               a_d     = bus.input_a;
               a_ack_d = 1'b0;
               state_d = ST_GET_B;
            end
         end
         ST_GET_B: begin
            b_ack_d = 1'b1;
            if (b_ack_q && bus.input_b_stb) begin
               b_d     = bus.input_b;
               op_d    = bus.input_op;
               b_ack_d = 1'b0;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            sign_a_d        = w_sa;
            sign_b_d        = w_sb;
            exp_a_d         = (w_ea == '0) ? XW'(1) : XW'(w_ea);
            exp_b_d         = (w_eb == '0) ? XW'(1) : XW'(w_eb);
            sig_a_d         = {1'b0, (w_ea != '0), w_fa, 3'b000};
            sig_b_d         = {1'b0, (w_eb != '0), w_fb, 3'b000};
            special_d       = w_special;
            special_z_d     = w_special_z;
            special_flags_d = w_special_flags;
            state_d         = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (w_a_big) begin
               exp_d   = exp_a_q;
               sig_b_d = w_sh_out;
            end else begin
               exp_d   = exp_b_q;
               sig_a_d = w_sh_out;
            end
            state_d = ST_ADD;
         end
         ST_ADD: begin
            if (sign_a_q == sign_b_q) begin
               sig_d  = sig_a_q + sig_b_q;
               sign_d = sign_a_q;
            end else if (sig_a_q >= sig_b_q) begin
               sig_d  = sig_a_q - sig_b_q;
               // exact cancellation of opposite signs is +0
               sign_d = (sig_a_q == sig_b_q) ? 1'b0 : sign_a_q;
            end else begin
               sig_d  = sig_b_q - sig_a_q;
               sign_d = sign_b_q;
            end
            state_d = ST_NORM;
         end
         ST_NORM: begin
            if (sig_q[SW-1]) begin
               sig_d = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
               exp_d = exp_q + XW'(1);
            end else begin
               sig_d = sig_q << w_norm_sh;
               exp_d = exp_q - $signed(w_norm_sh);
            end
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            inexact_d = sig_q[2] | sig_q[1] | sig_q[0];
            if (w_rnd[MAN_W+1]) begin
               sig_d = {1'b0, w_rnd[MAN_W+1:1], 3'b000};
               exp_d = exp_q + XW'(1);
            end else begin
               sig_d = {1'b0, w_rnd[MAN_W:0], 3'b000};
            end
            state_d = ST_PACK;
         end
         ST_PACK: begin
            if (special_q) begin
               z_d     = special_z_q;
               flags_d = special_flags_q;
            end else if (XW'(exp_q) >= EXP_MAX_X) begin
               z_d     = {sign_q, E_ONES, {MAN_W{1'b0}}};
               flags_d = 3'b011;
            end else begin
               // hidden bit clear means a denormal (or zero): exponent field 0
               z_d     = {sign_q, sig_q[SW-2] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}}, sig_q[SW-3:3]};
               flags_d = {2'b00, inexact_q};
            end
            state_d = ST_PUT_Z;
         end
         ST_PUT_Z: begin
            z_stb_d = 1'b1;
            if (z_stb_q && bus.output_z_ack) begin
               z_stb_d = 1'b0;
               state_d = ST_GET_A;
            end
         end
         default: state_d = ST_GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_GET_A;
         a_q             <= '0;
         b_q             <= '0;
         op_q            <= 1'b0;
         a_ack_q         <= 1'b0;
         b_ack_q         <= 1'b0;
         z_q             <= '0;
         flags_q         <= 3'b000;
         z_stb_q         <= 1'b0;
         sign_a_q        <= 1'b0;
         sign_b_q        <= 1'b0;
         exp_a_q         <= '0;
         exp_b_q         <= '0;
         sig_a_q         <= '0;
         sig_b_q         <= '0;
         special_q       <= 1'b0;
         special_z_q     <= '0;
         special_flags_q <= 3'b000;
         sign_q          <= 1'b0;
         exp_q           <= '0;
         sig_q           <= '0;
         inexact_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         a_q             <= a_d;
         b_q             <= b_d;
         op_q            <= op_d;
         a_ack_q         <= a_ack_d;
         b_ack_q         <= b_ack_d;
         z_q             <= z_d;
         flags_q         <= flags_d;
         z_stb_q         <= z_stb_d;
         sign_a_q        <= sign_a_d;
         sign_b_q        <= sign_b_d;
         exp_a_q         <= exp_a_d;
         exp_b_q         <= exp_b_d;
         sig_a_q         <= sig_a_d;
         sig_b_q         <= sig_b_d;
         special_q       <= special_d;
         special_z_q     <= special_z_d;
         special_flags_q <= special_flags_d;
         sign_q          <= sign_d;
         exp_q           <= exp_d;
         sig_q           <= sig_d;
         inexact_q       <= inexact_d;
      end
   end

   assign bus.input_a_ack  = a_ack_q;
   assign bus.input_b_ack  = b_ack_q;
   assign bus.output_z     = z_q;
   assign bus.output_flags = flags_q;
   assign bus.output_z_stb = z_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp_addsub : directed self-checking bench, single and half prec|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fp_addsub;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   fp_addsub_if #(.EXP_W(8), .MAN_W(23)) sp ();
   fp_addsub_if #(.EXP_W(5), .MAN_W(10)) hp ();

   fp_addsub #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(sp));
   fp_addsub #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .bus(hp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic sp_send(input logic [31:0] a, input logic [31:0] b, input logic op);
      int n;
      sp.input_a = a; sp.input_a_stb = 1'b1; n = 0;
      while (sp.input_a_ack !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1; sp.input_a_stb = 1'b0;
      tests++;
      if (n >= 50 || sp.input_a_ack !== 1'b0) begin
         fails++; $display("FAIL sp_a_handshake: wait=%0d ack_after=%b required wait<50 ack_after=0", n, sp.input_a_ack);
      end
      sp.input_b = b; sp.input_op = op; sp.input_b_stb = 1'b1; n = 0;
      while (sp.input_b_ack !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1; sp.input_b_stb = 1'b0;
      tests++;
      if (n >= 50 || sp.input_b_ack !== 1'b0) begin
         fails++; $display("FAIL sp_b_handshake: wait=%0d ack_after=%b required wait<50 ack_after=0", n, sp.input_b_ack);
      end
   endtask

   task automatic sp_wait(output int lat);
      lat = 0;
      while (sp.output_z_stb !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
      if (lat >= 50) begin
         tests++; fails++; $display("FAIL sp_result_timeout: no output_z_stb within 50 cycles");
      end
   endtask

   task automatic sp_ack();
      sp.output_z_ack = 1'b1; @(posedge clk); #1; sp.output_z_ack = 1'b0;
   endtask

   task automatic sp_run(input logic [31:0] a, input logic [31:0] b, input logic op,
                         output logic [31:0] z, output logic [2:0] f, output int lat);
      sp_send(a, b, op);
      sp_wait(lat);
      z = sp.output_z; f = sp.output_flags;
      sp_ack();
   endtask

   task automatic hp_run(input logic [15:0] a, input logic [15:0] b, input logic op,
                         output logic [15:0] z, output logic [2:0] f);
      int n;
      hp.input_a = a; hp.input_a_stb = 1'b1; n = 0;
      while (hp.input_a_ack !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1; hp.input_a_stb = 1'b0;
      hp.input_b = b; hp.input_op = op; hp.input_b_stb = 1'b1;
      while (hp.input_b_ack !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1; hp.input_b_stb = 1'b0;
      while (hp.output_z_stb !== 1'b1 && n < 150) begin @(posedge clk); #1; n++; end
      if (n >= 150) begin
         tests++; fails++; $display("FAIL hp_timeout: handshake/result wait exhausted");
      end
      z = hp.output_z; f = hp.output_flags;
      hp.output_z_ack = 1'b1; @(posedge clk); #1; hp.output_z_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (sp.output_z !== 32'h0 || sp.output_flags !== 3'b000 || sp.output_z_stb !== 1'b0) begin
         fails++; $display("FAIL reset_outputs: z=%h flags=%b stb=%b required 0/000/0", sp.output_z, sp.output_flags, sp.output_z_stb);
      end
      tests++;
      if (sp.input_a_ack !== 1'b0 || sp.input_b_ack !== 1'b0) begin
         fails++; $display("FAIL reset_acks: a_ack=%b b_ack=%b required 0/0", sp.input_a_ack, sp.input_b_ack);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (sp.input_a_ack !== 1'b1 || sp.input_b_ack !== 1'b0) begin
         fails++; $display("FAIL reset_release: a_ack=%b b_ack=%b required 1/0", sp.input_a_ack, sp.input_b_ack);
      end
   endtask

   task automatic test_basic();
      logic [31:0] z; logic [2:0] f; int lat;
      sp_run(32'h3F800000, 32'h40000000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h40400000 || f !== 3'b000) begin
         fails++; $display("FAIL add_1p2: z=%h flags=%b required 40400000/000", z, f);
      end
      tests++;
      if (lat !== 7) begin
         fails++; $display("FAIL latency: %0d cycles required 7", lat);
      end
   endtask

   task automatic test_zero();
      logic [31:0] z; logic [2:0] f; int lat;
      sp_run(32'h3F800000, 32'h3F800000, 1'b1, z, f, lat);
      tests++;
      if (z !== 32'h00000000 || f !== 3'b000) begin
         fails++; $display("FAIL sub_equal: z=%h flags=%b required 00000000/000", z, f);
      end
      sp_run(32'h80000000, 32'h80000000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h80000000 || f !== 3'b000) begin
         fails++; $display("FAIL negzero_sum: z=%h flags=%b required 80000000/000", z, f);
      end
   endtask

   task automatic test_special();
      logic [31:0] z; logic [2:0] f; int lat;
      sp_run(32'h7F800000, 32'h7F800000, 1'b1, z, f, lat);
      tests++;
      if (z !== 32'h7FC00000 || f !== 3'b100) begin
         fails++; $display("FAIL inf_minus_inf: z=%h flags=%b required 7FC00000/100", z, f);
      end
      sp_run(32'h7F800001, 32'h3F800000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h7FC00000 || f !== 3'b100) begin
         fails++; $display("FAIL snan_in: z=%h flags=%b required 7FC00000/100", z, f);
      end
      sp_run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h7F800000 || f !== 3'b011) begin
         fails++; $display("FAIL overflow: z=%h flags=%b required 7F800000/011", z, f);
      end
   endtask

   task automatic test_denormal();
      logic [31:0] z; logic [2:0] f; int lat;
      sp_run(32'h00000001, 32'h00000001, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h00000002 || f !== 3'b000) begin
         fails++; $display("FAIL denorm_add: z=%h flags=%b required 00000002/000", z, f);
      end
      sp_run(32'h00800000, 32'h00000001, 1'b1, z, f, lat);
      tests++;
      if (z !== 32'h007FFFFF || f !== 3'b000) begin
         fails++; $display("FAIL denorm_sub: z=%h flags=%b required 007FFFFF/000", z, f);
      end
   endtask

   task automatic test_rne();
      logic [31:0] z; logic [2:0] f; int lat;
      sp_run(32'h3F800000, 32'h33800000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h3F800000 || f !== 3'b001) begin
         fails++; $display("FAIL rne_tie_even: z=%h flags=%b required 3F800000/001", z, f);
      end
      sp_run(32'h3F800001, 32'h33800000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h3F800002 || f !== 3'b001) begin
         fails++; $display("FAIL rne_tie_odd: z=%h flags=%b required 3F800002/001", z, f);
      end
   endtask

   task automatic test_stall();
      logic [31:0] z0; logic [2:0] f0; int lat;
      sp_send(32'h3F800000, 32'h3F800000, 1'b0);
      sp_wait(lat);
      z0 = sp.output_z; f0 = sp.output_flags;
      tests++;
      if (z0 !== 32'h40000000 || f0 !== 3'b000) begin
         fails++; $display("FAIL stall_value: z=%h flags=%b required 40000000/000", z0, f0);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         tests++;
         if (sp.output_z_stb !== 1'b1 || sp.output_z !== 32'h40000000 || sp.output_flags !== 3'b000 ||
             sp.input_a_ack !== 1'b0 || sp.input_b_ack !== 1'b0) begin
            fails++; $display("FAIL stall_hold[%0d]: stb=%b z=%h flags=%b a_ack=%b b_ack=%b required 1/40000000/000/0/0",
                              i, sp.output_z_stb, sp.output_z, sp.output_flags, sp.input_a_ack, sp.input_b_ack);
         end
      end
      sp_ack();
      tests++;
      if (sp.output_z_stb !== 1'b0 || sp.input_a_ack !== 1'b0) begin
         fails++; $display("FAIL after_ack: stb=%b a_ack=%b required 0/0", sp.output_z_stb, sp.input_a_ack);
      end
      @(posedge clk); #1;
      tests++;
      if (sp.input_a_ack !== 1'b1) begin
         fails++; $display("FAIL a_ack_return: a_ack=%b required 1", sp.input_a_ack);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] z; logic [2:0] f; int lat; int seen;
      sp_send(32'h40000000, 32'h40000000, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (sp.output_z_stb !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++; $display("FAIL abort_no_stb: stb seen %0d cycles required 0", seen);
      end
      sp_run(32'h3F800000, 32'h40000000, 1'b0, z, f, lat);
      tests++;
      if (z !== 32'h40400000 || f !== 3'b000 || lat !== 7) begin
         fails++; $display("FAIL post_abort: z=%h flags=%b lat=%0d required 40400000/000/7", z, f, lat);
      end
   endtask

   task automatic test_half();
      logic [15:0] z; logic [2:0] f;
      hp_run(16'h3C00, 16'h3C00, 1'b0, z, f);
      tests++;
      if (z !== 16'h4000 || f !== 3'b000) begin
         fails++; $display("FAIL half_add: z=%h flags=%b required 4000/000", z, f);
      end
      hp_run(16'h7BFF, 16'h7BFF, 1'b0, z, f);
      tests++;
      if (z !== 16'h7C00 || f !== 3'b011) begin
         fails++; $display("FAIL half_overflow: z=%h flags=%b required 7C00/011", z, f);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      sp.input_a = '0; sp.input_a_stb = 1'b0; sp.input_b = '0; sp.input_op = 1'b0;
      sp.input_b_stb = 1'b0; sp.output_z_ack = 1'b0;
      hp.input_a = '0; hp.input_a_stb = 1'b0; hp.input_b = '0; hp.input_op = 1'b0;
      hp.input_b_stb = 1'b0; hp.output_z_ack = 1'b0;
      test_reset();
      test_basic();
      test_zero();
      test_special();
      test_denormal();
      test_rne();
      test_stall();
      test_reset_mid();
      test_half();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
